// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_seq_ctrl_pkg;

    // Datapath word width. The 64-bit accumulator and the 5-bit step counter
    // both assume 32-bit operands.
    localparam int WORD_LEN    = 32;
    localparam int MUL_CNT_LEN = 5;

    // Counter value at which the final shift-add step runs.
    localparam logic [MUL_CNT_LEN-1:0] MUL_LAST_STEP = '1;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath: operand latch, 64-bit accumulator, result regs.
// Latency: 32 step cycles after load; HIGH/LOW are written on the final step.
// Backpressure: none; sequencing comes entirely from load/step/finish.
//
// Ports: clk, rst (async active-low), load (latch operands), step (one
// shift-add), finish (final step, write HIGH/LOW), signed_op, opA, opB,
// HIGH, LOW.
// Optional feature: MUL_SIGNED_EN enables signed multiplies via signed_op.
module mul_datapath
    import mul_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                finish,
    input  logic                signed_op,
    input  logic [WORD_LEN-1:0] opA,
    input  logic [WORD_LEN-1:0] opB,
    output logic [WORD_LEN-1:0] HIGH,
    output logic [WORD_LEN-1:0] LOW
);

    logic [WORD_LEN-1:0]   mcand;
    logic [2*WORD_LEN-1:0] acc;
    logic [2*WORD_LEN-1:0] acc_nxt;
    logic [2*WORD_LEN-1:0] prod;
    logic [WORD_LEN:0]     partial;
    logic [WORD_LEN-1:0]   a_mag;
    logic [WORD_LEN-1:0]   b_mag;

    // The multiplier lives in the low half of the accumulator and is consumed
    // one bit per step while partial sums enter the high half, so after 32
    // steps the accumulator holds the full product.
    always_comb begin
        partial = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]};
        if (acc[0]) begin
            partial = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]} + {1'b0, mcand};
        end
        acc_nxt = {partial, acc[WORD_LEN-1:1]};
    end

`ifdef MUL_SIGNED_EN
    logic neg_in;
    logic neg_q;

    // Signed operands are reduced to magnitudes at latch time. The magnitude
    // of 0x80000000 is 2^31, which is still representable unsigned.
    always_comb begin
        a_mag  = opA;
        b_mag  = opB;
        neg_in = 1'b0;
        if (signed_op) begin
            if (opA[WORD_LEN-1]) a_mag = -opA;
            if (opB[WORD_LEN-1]) b_mag = -opB;
            neg_in = opA[WORD_LEN-1] ^ opB[WORD_LEN-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= neg_in;
        end
    end

    assign prod = neg_q ? -acc_nxt : acc_nxt;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag = opA;
    assign b_mag = opB;
    assign prod  = acc_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand <= '0;
            acc   <= '0;
            HIGH  <= '0;
            LOW   <= '0;
        end else begin
            if (load) begin
                mcand <= a_mag;
                acc   <= {{WORD_LEN{1'b0}}, b_mag};
            end else if (step) begin
                acc <= acc_nxt;
            end
            if (finish) begin
                HIGH <= prod[2*WORD_LEN-1:WORD_LEN];
                LOW  <= prod[WORD_LEN-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiply controller: IDLE/RUN/DONE FSM, step counter, stall/done.
// Latency: MUL_EN in cycle k -> done pulse in cycle k+33, IDLE again in k+34.
// Backpressure: stall holds the pipeline from the request cycle through RUN.
//
// Ports: clk, rst (async active-low), MUL_EN, flush, opA, opB, signed_op,
// stall, busy, done, HIGH, LOW.
// Optional feature: MUL_SIGNED_EN enables signed multiplies via signed_op.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                MUL_EN,
    input  logic                flush,
    input  logic [WORD_LEN-1:0] opA,
    input  logic [WORD_LEN-1:0] opB,
    input  logic                signed_op,
    output logic                stall,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] HIGH,
    output logic [WORD_LEN-1:0] LOW
);

    mul_state_t             state_q;
    mul_state_t             state_d;
    logic [MUL_CNT_LEN-1:0] count_q;
    logic                   load;
    logic                   step;
    logic                   finish;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush overrides every transition, including a start from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (MUL_EN) state_d = MUL_RUN;
            MUL_RUN:  if (count_q == MUL_LAST_STEP) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
        if (flush) state_d = MUL_IDLE;
    end

    assign load   = (state_q == MUL_IDLE) && MUL_EN && !flush;
    assign step   = (state_q == MUL_RUN) && !flush;
    assign finish = step && (count_q == MUL_LAST_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (state_q == MUL_RUN) begin
            count_q <= count_q + 1'b1;
        end
    end

    // stall is gated by rst so it drops the moment reset asserts, even if
    // MUL_EN is still high; it is low in DONE so the instruction advances
    // together with its result.
    assign stall = rst && !flush && (load || (state_q == MUL_RUN));
    assign busy  = (state_q == MUL_RUN);
    assign done  = (state_q == MUL_DONE);

    mul_datapath u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .signed_op (signed_op),
        .opA       (opA),
        .opB       (opB),
        .HIGH      (HIGH),
        .LOW       (LOW)
    );

endmodule
